// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Fetch control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

  // IF/ID register action for the coming edge
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } if_id_op_e;

  // IF/ID payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between fetch stage and imem.
interface if_stage_if;

  logic                             imem_req;
  logic [if_stage_pkg::XLEN-1:0]    imem_addr;
  logic                             imem_ready;
  logic [if_stage_pkg::XLEN-1:0]    imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold, or bubble/flush on each edge.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  if_id_op_e op_i,
  input  if_id_t    data_i,
  output if_id_t    q_o,
  output logic      valid_o
);

  if_id_t q_q;
  logic   valid_q;

  // Bubble keeps pc4 so downstream still sees the last sequential address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q.instr <= NOP_INSTR;
      q_q.pc4   <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (op_i)
        IFID_LOAD: begin
          q_q     <= data_i;
          valid_q <= 1'b1;
        end
        IFID_BUBBLE: begin
          q_q.instr <= NOP_INSTR;
          valid_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign q_o     = q_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM with branch redirect, IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold_pc,
  input  logic            hold_if_id,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
);

  if_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redir_q;
  logic            req_q;
  logic [XLEN-1:0] pc_plus4;
  logic            ready;
  if_id_op_e       if_id_op;
  if_id_t          fetch_data;
  if_id_t          if_id_q;

  assign ready      = imem.imem_ready;
  assign pc_plus4   = pc_q + XLEN'(4);
  assign fetch_data = '{instr: imem.imem_rdata, pc4: pc_plus4};

  // Address is the PC itself, so it stays stable while a request is pending
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  // Fetch FSM; a branch during a pending request parks the target until the
  // outstanding response arrives and is thrown away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          if (branch_taken) pc_q <= branch_target;
        end
        FETCH: begin
          req_q <= 1'b1;
          if (ready) begin
            if (branch_taken) pc_q <= branch_target;
            else if (!hold_pc) pc_q <= pc_plus4;
          end else if (branch_taken) begin
            redir_q <= branch_target;
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          req_q <= 1'b1;
          if (branch_taken) redir_q <= branch_target;
          if (ready) begin
            pc_q    <= branch_taken ? branch_target : redir_q;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID action: branch flush beats hold; only a completed FETCH loads
  always_comb begin
    if_id_op = IFID_BUBBLE;
    if (branch_taken) if_id_op = IFID_BUBBLE;
    else if (hold_if_id) if_id_op = IFID_HOLD;
    else if (state_q == FETCH && ready) if_id_op = IFID_LOAD;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .op_i    (if_id_op),
    .data_i  (fetch_data),
    .q_o     (if_id_q),
    .valid_o (if_id_valid)
  );

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;

endmodule

// File: tb/tb_if_stage.sv
// Scenario bench for if_stage with a scoreboard of expected IF/ID loads.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold_pc;
  logic        hold_if_id;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;
  if_id_t sb[$];

  if_stage_if bus();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold_pc       (hold_pc),
    .hold_if_id    (hold_if_id),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One completed sequential fetch at pc with the result checked one edge later
  task automatic do_fetch(input logic [31:0] pc);
    if_id_t e;
    checks++;
    if (bus.imem_addr !== pc) begin
      errors++;
      $display("FAIL fetch_addr: got %h want %h", bus.imem_addr, pc);
    end
    sb.push_back('{instr: mem_word(pc), pc4: pc + 32'd4});
    tick();
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      checks++;
      if (if_id_instr !== e.instr) begin
        errors++;
        $display("FAIL fetch_instr: got %h want %h", if_id_instr, e.instr);
      end
      checks++;
      if (if_id_pc4 !== e.pc4) begin
        errors++;
        $display("FAIL fetch_pc4: got %h want %h", if_id_pc4, e.pc4);
      end
      checks++;
      if (if_id_valid !== 1'b1) begin
        errors++;
        $display("FAIL fetch_valid: got %b want 1", if_id_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold_pc = 1'b0; hold_if_id = 1'b0; branch_taken = 1'b0;
    branch_target = '0; bus.imem_ready = 1'b1;
    tick(); tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", if_id_instr, NOP); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 0", if_id_pc4); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_fetch_req: got %b want 1", bus.imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", if_id_valid); end
  endtask

  task automatic test_sequential();
    do_fetch(32'h0);
    do_fetch(32'h4);
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr: got %h want 8", bus.imem_addr); end
  endtask

  task automatic test_hold();
    hold_pc = 1'b1; hold_if_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL hold_addr: got %h want 8", bus.imem_addr); end
      checks++; if (if_id_instr !== mem_word(32'h4)) begin errors++; $display("FAIL hold_instr: got %h want %h", if_id_instr, mem_word(32'h4)); end
      checks++; if (if_id_pc4 !== 32'h8) begin errors++; $display("FAIL hold_pc4: got %h want 8", if_id_pc4); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", if_id_valid); end
    end
    hold_pc = 1'b0; hold_if_id = 1'b0;
    do_fetch(32'h8);
    do_fetch(32'hC);
  endtask

  task automatic test_bubbles();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL bub_valid: got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL bub_instr: got %h want %h", if_id_instr, NOP); end
      checks++; if (if_id_pc4 !== 32'h10) begin errors++; $display("FAIL bub_pc4: got %h want 10", if_id_pc4); end
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL bub_addr: got %h want 10", bus.imem_addr); end
    end
  endtask

  task automatic test_discard();
    bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL disc_addr: got %h want 10", bus.imem_addr); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL disc_req: got %b want 1", bus.imem_req); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL disc_valid: got %b want 0", if_id_valid); end
      if (i < 2) tick();
    end
    bus.imem_ready = 1'b1;
    tick();
    checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL disc_redirect: got %h want 200", bus.imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL disc_drop_valid: got %b want 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL disc_drop_instr: got %h want %h", if_id_instr, NOP); end
    do_fetch(32'h200);
  endtask

  task automatic test_branch();
    bus.imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got %h want 100", bus.imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL br_instr: got %h want %h", if_id_instr, NOP); end
    checks++; if (if_id_pc4 !== 32'h204) begin errors++; $display("FAIL br_pc4: got %h want 204", if_id_pc4); end
    do_fetch(32'h100);
    hold_pc = 1'b1; hold_if_id = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    hold_pc = 1'b0; hold_if_id = 1'b0; branch_taken = 1'b0;
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL br_hold_addr: got %h want 40", bus.imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_hold_valid: got %b want 0", if_id_valid); end
    do_fetch(32'h40);
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    do_fetch(32'hFFFF_FFFC);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_reset_discard();
    bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_target = 32'h340;
    tick();
    branch_taken = 1'b0; bus.imem_ready = 1'b1;
    tick();
    checks++; if (bus.imem_addr !== 32'h340) begin errors++; $display("FAIL latest_target: got %h want 340", bus.imem_addr); end
    do_fetch(32'h340);
    bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
    tick();
    branch_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr: got %h want 0", bus.imem_addr); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL arst_instr: got %h want %h", if_id_instr, NOP); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL arst_pc4: got %h want 0", if_id_pc4); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", if_id_valid); end
    tick(); tick();
    rst_n = 1'b1; bus.imem_ready = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %b want 1", bus.imem_req); end
    do_fetch(32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_bubbles();
    test_discard();
    test_branch();
    test_wrap();
    test_reset_discard();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
